fp_encode_seq: RTL and testbench
================================

// Module: fp_encode_seq
// PURPOSE
//  Sequential, parametrised two's-complement -> compact float encoder (sign, EXP_W exponent, MAN_W significand).
//  Normalises by shifting one bit per clock, then rounds half-up; results handed off over valid/ready.
//  Feeds the display/packing path; replaces the single-shot combinational converter for arbitrary widths.
// PARAMETERS
//  EXP_W  3   exponent width; MAX_EXP = 2**EXP_W-1
//  MAN_W  4   significand width
//  IN_W   12  input width; must equal MAN_W+MAX_EXP+1 (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block accepts; high only in IDLE and rst low
//  in_data    in   IN_W   two's-complement sample
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  out_sign   out  1      sign of sample
//  out_exp    out  EXP_W  exponent
//  out_sig    out  MAN_W  significand
//  out_sat    out  1      result clamped to max magnitude
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_sign, out_exp, out_sig, out_sat = 0; in_ready = 0 while rst high.
//  Value = (-1)^sign * sig * 2^exp. Magnitude register M is IN_W-1 bits.
//  IDLE: accept on in_valid&&in_ready edge: sign=in_data[IN_W-1]; M=|in_data|; -2^(IN_W-1) loads all-ones, sets sat;
//    E=MAX_EXP; -> NORM.
//  NORM: if M[IN_W-2]==1 or E==0 -> ROUND; else M<=M<<1, E<=E-1 (stay). S = shifts done, 0..MAX_EXP.
//  ROUND: sig=M[IN_W-2 -: MAN_W], r=next lower bit. r=0: keep. r=1: sig+1; on carry-out sig=1<<(MAN_W-1), E+1;
//    if E already MAX_EXP: sig=all ones, E=MAX_EXP, sat=1. Register outputs, out_valid=1 -> HOLD.
//  HOLD: outputs stable while out_valid&&!out_ready; on out_ready -> IDLE, out_valid=0 same edge. Output fields
//    keep last value after handshake.
//  Latency: out_valid rises S+2 edges after accepting edge (S+1 without rounding). One sample in flight; no overlap.
//  Zero input: S=MAX_EXP, result sign 0, E=0, sig=0, sat=0.
//  rst asserted mid-operation: immediate abort to reset values; in-flight sample discarded, never reported.
//  in_valid outside IDLE ignored (in_ready low); in_data sampled only at accept edge.
// CONFIGURATION
//  FP_ENCODE_ROUND_EN defined: ROUND state present, round half-up as above.
//  Undefined: truncation; NORM exits straight to HOLD with sig = top MAN_W bits of M; sat only from -2^(IN_W-1).
// STRUCTURE
//  fpconv_pkg: state encoding (IDLE/NORM/ROUND/HOLD), MAX_EXP function, packed result struct {sign,exp,sig,sat}.
//  Sub-module fp_round_unit: combinational {sig,r,E} -> {sig',E',sat}; one instance in ROUND path.
//  Top: FSM, M/E shift register, output register, handshake.
// TESTING (defaults, macro defined; result written {sign,exp,sig})
//  in=12'd5 -> S=7, out 0_000_0101 (0x05), out_valid 9 edges after accept, sat=0.
//  in=12'b111111111000 (-8) -> 1_000_1000 (0x88); in=12'hFFF (-1) -> 1_000_0001 (0x81).
//  in=12'h14C (332) -> S=2, 0_101_1010 (0x5A); in=12'h02F (47) -> round up 0_010_1100 (0x2C).
//  in=12'h07C (124) -> carry 0_100_1000 (0x48); in=12'h800 -> 1_111_1111 (0xFF), sat=1; in=0 -> 0x00.
//  Backpressure: out_ready low 5 cycles -> outputs stable, in_ready low; release -> IDLE next edge, next sample accepted.
//  rst pulsed mid-NORM -> outputs 0 immediately, no out_valid for that sample; new sample after release correct.

Source files
------------

// File: rtl/fpconv_pkg.sv
// Shared types for the two's-complement to compact-float encoder: FSM state
// encoding, exponent range helper and the default-width packed result record.
package fpconv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_HOLD  = 2'd3
   } fp_state_t;

   localparam int FP_EXP_W = 3;
   localparam int FP_MAN_W = 4;

   function automatic int max_exp(input int exp_w);
      return (32'sd1 <<< exp_w) - 32'sd1;
   endfunction

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] sig;
      logic                sat;
   } fp_result_t;

endpackage

// File: rtl/fp_round_unit.sv
// Round-half-up step for a normalised significand: adds the guard bit, renormalises
// on carry-out and clamps to the largest representable value at the top exponent.
module fp_round_unit
   import fpconv_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic [MAN_W-1:0] sig,
   input  logic             r,
   input  logic [EXP_W-1:0] exp,
   output logic [MAN_W-1:0] sig_rnd,
   output logic [EXP_W-1:0] exp_rnd,
   output logic             sat
);

   logic [MAN_W:0] sig_inc_s;

   assign sig_inc_s = {1'b0, sig} + {{MAN_W{1'b0}}, 1'b1};

   // Carry-out becomes an exponent bump unless the exponent is already at its ceiling.
   always_comb begin
      sig_rnd = sig;
      exp_rnd = exp;
      sat     = 1'b0;
      if (!r) begin
         sig_rnd = sig;
      end else if (!sig_inc_s[MAN_W]) begin
         sig_rnd = sig_inc_s[MAN_W-1:0];
      end else if (exp == {EXP_W{1'b1}}) begin
         sig_rnd = {MAN_W{1'b1}};
         exp_rnd = {EXP_W{1'b1}};
         sat     = 1'b1;
      end else begin
         sig_rnd = {1'b1, {(MAN_W-1){1'b0}}};
         exp_rnd = exp + {{(EXP_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/fp_encode_seq.sv
// Sequential two's-complement to {sign, exp, sig} encoder, one normalising shift per clock.
// Define FP_ENCODE_ROUND_EN to round half-up; otherwise the significand is truncated.
module fp_encode_seq
   import fpconv_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   parameter int IN_W  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_sig,
   output logic             out_sat
);

   localparam int MAX_EXP = max_exp(EXP_W);
   localparam int M_W     = IN_W - 1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] sig;
      logic             sat;
   } res_t;

   if (IN_W != MAN_W + MAX_EXP + 1) begin : g_width_check
      $error("fp_encode_seq: IN_W must equal MAN_W + 2**EXP_W");
   end

   fp_state_t        state_r;
   logic [M_W-1:0]   mag_r;
   logic [EXP_W-1:0] exp_r;
   logic             sign_r;
   logic             sat_r;
   logic             in_ready_r;
   logic             out_valid_r;
   res_t             res_r;

   logic [M_W-1:0]   mag_load_s;
   logic             sat_load_s;

   // Magnitude of the incoming sample; the most negative code has no positive twin and clamps.
   always_comb begin
      mag_load_s = '0;
      sat_load_s = 1'b0;
      if (in_data == {1'b1, {M_W{1'b0}}}) begin
         mag_load_s = '1;
         sat_load_s = 1'b1;
      end else if (in_data[IN_W-1]) begin
         mag_load_s = ~in_data[M_W-1:0] + {{(M_W-1){1'b0}}, 1'b1};
      end else begin
         mag_load_s = in_data[M_W-1:0];
      end
   end

`ifdef FP_ENCODE_ROUND_EN
   logic [MAN_W-1:0] sig_rnd_s;
   logic [EXP_W-1:0] exp_rnd_s;
   logic             sat_rnd_s;

   fp_round_unit #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sig     (mag_r[M_W-1 -: MAN_W]),
      .r       (mag_r[M_W-1-MAN_W]),
      .exp     (exp_r),
      .sig_rnd (sig_rnd_s),
      .exp_rnd (exp_rnd_s),
      .sat     (sat_rnd_s)
   );
`endif

   // Control FSM with the normalising shift register and the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mag_r       <= '0;
         exp_r       <= '0;
         sign_r      <= 1'b0;
         sat_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         res_r       <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               in_ready_r <= 1'b1;
               if (in_valid && in_ready_r) begin
                  sign_r     <= in_data[IN_W-1];
                  mag_r      <= mag_load_s;
                  sat_r      <= sat_load_s;
                  exp_r      <= '1;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_NORM;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_NORM: begin
               if (mag_r[M_W-1] || (exp_r == '0)) begin
`ifdef FP_ENCODE_ROUND_EN
                  state_r <= ST_ROUND;
`else
                  res_r       <= '{sign_r, exp_r, mag_r[M_W-1 -: MAN_W], sat_r};
                  out_valid_r <= 1'b1;
                  state_r     <= ST_HOLD;
`endif
               end else begin
                  mag_r <= mag_r << 1;
                  exp_r <= exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
               end
            end
            ST_ROUND: begin
`ifdef FP_ENCODE_ROUND_EN
               res_r       <= '{sign_r, exp_rnd_s, sig_rnd_s, sat_r | sat_rnd_s};
               out_valid_r <= 1'b1;
               state_r     <= ST_HOLD;
`else
               in_ready_r <= 1'b1;
               state_r    <= ST_IDLE;
`endif
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_sign  = res_r.sign;
   assign out_exp   = res_r.exp;
   assign out_sig   = res_r.sig;
   assign out_sat   = res_r.sat;

endmodule

// File: tb/tb_fp_encode_seq.sv
// Scoreboard bench for fp_encode_seq: directed samples push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_encode_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = 12'h000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_sign;
   logic [2:0]  out_exp;
   logic [3:0]  out_sig;
   logic        out_sat;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

`ifdef FP_ENCODE_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif

   typedef struct {
      logic [7:0] word;
      logic       sat;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb_q[$];

   fp_encode_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_sig   (out_sig),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: records when out_valid rises and checks each handshaked result.
   initial begin
      exp_t e;
      int   rise_cyc;
      logic vld_q;
      rise_cyc = 0;
      vld_q    = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !vld_q) rise_cyc = cyc;
         vld_q = out_valid;
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got %0h with empty scoreboard", {out_sign, out_exp, out_sig});
            end else begin
               e = sb_q.pop_front();
               chk("result", {24'h0, out_sign, out_exp, out_sig}, {24'h0, e.word});
               chk("sat", {31'h0, out_sat}, {31'h0, e.sat});
               chk("latency", rise_cyc - e.acc, e.lat);
            end
         end
      end
   end

   task automatic send(input logic [11:0] d, input logic [7:0] w_rnd, input logic [7:0] w_trn,
                       input logic s_rnd, input logic s_trn, input int shifts, input int bp);
      int         t;
      exp_t       e;
      logic [8:0] snap;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1 for %0h", d);
         return;
      end
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = (bp == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      e.word = (RND != 0) ? w_rnd : w_trn;
      e.sat  = (RND != 0) ? s_rnd : s_trn;
      e.lat  = shifts + 1 + RND;
      e.acc  = cyc;
      sb_q.push_back(e);
      chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
      t = 0;
      while (!out_valid && t < 40) begin
         @(posedge clk); #1; t++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("FAIL out_timeout: out_valid got 0 expected 1 for %0h", d);
         sb_q.delete();
         out_ready = 1'b1;
         return;
      end
      if (bp > 0) begin
         snap = {out_sign, out_exp, out_sig, out_sat};
         for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_hold", {23'h0, out_sign, out_exp, out_sig, out_sat}, {23'h0, snap});
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("handshake_drop", {31'h0, out_valid}, 32'h0);
      chk("idle_ready", {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_outputs", {22'h0, out_valid, out_sign, out_exp, out_sig, out_sat}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      send(12'h005, 8'h05, 8'h05, 1'b0, 1'b0, 7, 0);
      send(12'hFF8, 8'h88, 8'h88, 1'b0, 1'b0, 7, 0);
      send(12'hFFF, 8'h81, 8'h81, 1'b0, 1'b0, 7, 0);
      send(12'h14C, 8'h5A, 8'h5A, 1'b0, 1'b0, 2, 0);
      send(12'h02F, 8'h2C, 8'h2B, 1'b0, 1'b0, 5, 0);
      send(12'hFD1, 8'hAC, 8'hAB, 1'b0, 1'b0, 5, 0);
      send(12'h07C, 8'h48, 8'h3F, 1'b0, 1'b0, 4, 0);
      send(12'h7FF, 8'h7F, 8'h7F, 1'b1, 1'b0, 0, 0);
      send(12'h800, 8'hFF, 8'hFF, 1'b1, 1'b1, 0, 0);

      // Abort a sample mid-normalisation; it must never be reported.
      in_valid = 1'b1;
      in_data  = 12'h005;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_outputs", {22'h0, out_valid, out_sign, out_exp, out_sig, out_sat}, 32'h0);
      chk("abort_in_ready", {31'h0, in_ready}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      send(12'h07C, 8'h48, 8'h3F, 1'b0, 1'b0, 4, 0);
      send(12'h14C, 8'h5A, 8'h5A, 1'b0, 1'b0, 2, 5);
      send(12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 7, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
